// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit that owns the HI/LO registers.
//
// Ports:
//   clk      - single clock, all state changes on the rising edge
//   reset    - synchronous, active-high
//   start    - begin an operation (sampled only in IDLE)
//   op       - 00 multu, 01 mult, 10 divu, 11 div
//   a, b     - multiplicand/dividend and multiplier/divisor
//   mthi     - write a into HI (IDLE only, lower priority than start)
//   mtlo     - write a into LO (IDLE only, lower priority than start)
//   busy     - operation in progress, core stalls while high
//   done     - one-cycle pulse when HI/LO hold the new result
//   divzero  - last completed divide had a zero divisor (cleared by start)
//   hi, lo   - architectural HI/LO registers
//
// A signed operation is run on operand magnitudes and the sign is fixed up
// in the FIX state, so HI/LO only ever show the final result.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]   count;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               b_zero;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;

    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_next;

    function automatic logic [WIDTH-1:0] neg_word(input logic [WIDTH-1:0] v,
                                                  input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_wide(input logic [2*WIDTH-1:0] v,
                                                    input logic n);
        return n ? -v : v;
    endfunction

    // Operand magnitudes; op[0] marks the signed variants.
    assign sign_a = op[0] & a[WIDTH-1];
    assign sign_b = op[0] & b[WIDTH-1];
    assign mag_a  = neg_word(a, sign_a);
    assign mag_b  = neg_word(b, sign_b);

    // Shift-add step: multiplier sits in the low half and is consumed LSB first
    // while the partial product grows in from the top.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide step: remainder in the high half, dividend bits shift
    // out of the low half while quotient bits shift in.
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff     = rem_sh - {1'b0, opnd};
    assign q_bit    = ~diff[WIDTH];
    assign rem_new  = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_next = {rem_new, acc[WIDTH-2:0], q_bit};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count == CNT_W'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control and architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            divzero <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        divzero <= 1'b0;
                        count   <= '0;
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                CALC: count <= count + CNT_W'(1);
                FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (is_div && b_zero) begin
                        divzero <= 1'b1;
                        hi      <= a_raw;
                        lo      <= '1;
                    end else if (is_div) begin
                        hi <= neg_word(acc[2*WIDTH-1:WIDTH], neg_rem);
                        lo <= neg_word(acc[WIDTH-1:0], neg_res);
                    end else begin
                        {hi, lo} <= neg_wide(acc, neg_res);
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers; they are always loaded at start before use.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    is_div  <= op[1];
                    neg_res <= sign_a ^ sign_b;
                    neg_rem <= sign_a;
                    b_zero  <= (b == '0);
                    a_raw   <= a;
                    opnd    <= op[1] ? mag_b : mag_a;
                    acc     <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                end
            end
            CALC:    acc <= is_div ? div_next : mul_next;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit with hand-computed expected values.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        busy, done, divzero;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .divzero(divzero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for done.
    // lat: edges after the start edge until done; bcnt: samples with busy high;
    // chg: samples before done where hi/lo differed from their start-cycle value.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bcnt, output int chg, output logic dz1);
        logic [31:0] h0, l0;
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0; a = 32'h5A5A_A5A5; b = 32'hA5A5_5A5A;
        dz1 = divzero;
        h0 = hi; l0 = lo;
        lat = 0; bcnt = 0; chg = 0;
        while (!done && lat < 50) begin
            if (busy) bcnt++;
            if (hi !== h0 || lo !== l0) chg++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (divzero !== 1'b0) begin failures++; $display("FAIL reset_divzero got=%b exp=0", divzero); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_multu_max();
        int lat, bcnt, chg; logic dz1;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, chg, dz1);
        checks++; if (lat !== 33) begin failures++; $display("FAIL multu_latency got=%0d exp=33", lat); end
        checks++; if (bcnt !== 33) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=33", bcnt); end
        checks++; if (chg !== 0) begin failures++; $display("FAIL multu_hold_during_calc got=%0d exp=0", chg); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL multu_busy_at_done got=%b exp=0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL multu_done_pulse got=%b exp=0", done); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi_hold got=%h exp=fffffffe", hi); end
    endtask

    task automatic test_signed();
        int lat, bcnt, chg; logic dz1;
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, lat, bcnt, chg, dz1);
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_neg_lo got=%h exp=ffffffeb", lo); end
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bcnt, chg, dz1);
        checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg_quot got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_neg_rem got=%h exp=ffffffff", hi); end
        checks++; if (lat !== 33) begin failures++; $display("FAIL div_latency got=%0d exp=33", lat); end
        run_op(2'b11, 32'd7, 32'hFFFF_FFFE, lat, bcnt, chg, dz1);
        checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_negdivisor_quot got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'h0000_0001) begin failures++; $display("FAIL div_negdivisor_rem got=%h exp=00000001", hi); end
        run_op(2'b10, 32'd7, 32'd2, lat, bcnt, chg, dz1);
        checks++; if (lo !== 32'd3) begin failures++; $display("FAIL divu_quot got=%h exp=00000003", lo); end
        checks++; if (hi !== 32'd1) begin failures++; $display("FAIL divu_rem got=%h exp=00000001", hi); end
        checks++; if (divzero !== 1'b0) begin failures++; $display("FAIL divu_divzero got=%b exp=0", divzero); end
        tick();
    endtask

    task automatic test_divzero();
        int lat, bcnt, chg; logic dz1;
        run_op(2'b10, 32'h0000_0064, 32'h0, lat, bcnt, chg, dz1);
        checks++; if (lat !== 33) begin failures++; $display("FAIL dz_latency got=%0d exp=33", lat); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dz_lo got=%h exp=ffffffff", lo); end
        checks++; if (hi !== 32'h0000_0064) begin failures++; $display("FAIL dz_hi got=%h exp=00000064", hi); end
        checks++; if (divzero !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", divzero); end
        tick(); tick(); tick();
        checks++; if (divzero !== 1'b1) begin failures++; $display("FAIL dz_sticky got=%b exp=1", divzero); end
        run_op(2'b11, 32'hFFFF_FF9C, 32'h0, lat, bcnt, chg, dz1);
        checks++; if (dz1 !== 1'b0) begin failures++; $display("FAIL dz_clear_on_start got=%b exp=0", dz1); end
        checks++; if (hi !== 32'hFFFF_FF9C) begin failures++; $display("FAIL dz_signed_hi got=%h exp=ffffff9c", hi); end
        checks++; if (divzero !== 1'b1) begin failures++; $display("FAIL dz_signed_flag got=%b exp=1", divzero); end
        run_op(2'b10, 32'd9, 32'd3, lat, bcnt, chg, dz1);
        checks++; if (dz1 !== 1'b0) begin failures++; $display("FAIL dz_clear_next got=%b exp=0", dz1); end
        checks++; if (divzero !== 1'b0) begin failures++; $display("FAIL dz_after_normal got=%b exp=0", divzero); end
        tick();
    endtask

    task automatic test_overflow();
        int lat, bcnt, chg; logic dz1;
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, chg, dz1);
        checks++; if (lo !== 32'h8000_0000) begin failures++; $display("FAIL ovf_quot got=%h exp=80000000", lo); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL ovf_rem got=%h exp=00000000", hi); end
        tick();
    endtask

    task automatic test_ignored();
        int lat;
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        repeat (9) begin tick(); lat++; end
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; a = 32'hDEAD_BEEF; op = 2'b10;
        tick(); lat++;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        checks++; if (hi !== h0) begin failures++; $display("FAIL ign_mthi_busy got=%h exp=%h", hi, h0); end
        checks++; if (lo !== l0) begin failures++; $display("FAIL ign_mtlo_busy got=%h exp=%h", lo, l0); end
        while (!done && lat < 50) begin tick(); lat++; end
        checks++; if (lat !== 33) begin failures++; $display("FAIL ign_latency got=%0d exp=33", lat); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL ign_hi got=%h exp=00000000", hi); end
        checks++; if (lo !== 32'd6) begin failures++; $display("FAIL ign_lo got=%h exp=00000006", lo); end
        tick(); tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_no_queue got=%b exp=0", busy); end
    endtask

    task automatic test_moves();
        mthi = 1'b1; mtlo = 1'b1; a = 32'h1234_5678;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        checks++; if (hi !== 32'h1234_5678) begin failures++; $display("FAIL mv_both_hi got=%h exp=12345678", hi); end
        checks++; if (lo !== 32'h1234_5678) begin failures++; $display("FAIL mv_both_lo got=%h exp=12345678", lo); end
        mthi = 1'b1; a = 32'hAAAA_0000;
        tick();
        mthi = 1'b0;
        checks++; if (hi !== 32'hAAAA_0000) begin failures++; $display("FAIL mv_hi_only got=%h exp=aaaa0000", hi); end
        checks++; if (lo !== 32'h1234_5678) begin failures++; $display("FAIL mv_lo_untouched got=%h exp=12345678", lo); end
        mtlo = 1'b1; a = 32'h0000_BBBB;
        tick();
        mtlo = 1'b0;
        checks++; if (lo !== 32'h0000_BBBB) begin failures++; $display("FAIL mv_lo_only got=%h exp=0000bbbb", lo); end
        checks++; if (hi !== 32'hAAAA_0000) begin failures++; $display("FAIL mv_hi_untouched got=%h exp=aaaa0000", hi); end
    endtask

    task automatic test_start_priority();
        int lat;
        op = 2'b00; a = 32'd4; b = 32'd3; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        tick();
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        checks++; if (hi !== 32'hAAAA_0000) begin failures++; $display("FAIL prio_mthi_dropped got=%h exp=aaaa0000", hi); end
        checks++; if (lo !== 32'h0000_BBBB) begin failures++; $display("FAIL prio_mtlo_dropped got=%h exp=0000bbbb", lo); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL prio_busy got=%b exp=1", busy); end
        lat = 0;
        while (!done && lat < 50) begin tick(); lat++; end
        checks++; if (lo !== 32'd12) begin failures++; $display("FAIL prio_lo got=%h exp=0000000c", lo); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL prio_hi got=%h exp=00000000", hi); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, chg; logic dz1;
        op = 2'b00; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL rstmid_hi got=%h exp=00000000", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL rstmid_lo got=%h exp=00000000", lo); end
        tick(); tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_stays_idle got=%b exp=0", busy); end
        run_op(2'b00, 32'd5, 32'd6, lat, bcnt, chg, dz1);
        checks++; if (lat !== 33) begin failures++; $display("FAIL rstmid_fresh_latency got=%0d exp=33", lat); end
        checks++; if (lo !== 32'd30) begin failures++; $display("FAIL rstmid_fresh_lo got=%h exp=0000001e", lo); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL rstmid_fresh_hi got=%h exp=00000000", hi); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, bcnt, chg; logic dz1;
        run_op(2'b10, 32'd100, 32'd7, lat, bcnt, chg, dz1);
        checks++; if (lo !== 32'd14) begin failures++; $display("FAIL b2b_first_quot got=%h exp=0000000e", lo); end
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL b2b_first_rem got=%h exp=00000002", hi); end
        run_op(2'b00, 32'h0001_0000, 32'h0001_0000, lat, bcnt, chg, dz1);
        checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=33", lat); end
        checks++; if (hi !== 32'h0000_0001) begin failures++; $display("FAIL b2b_second_hi got=%h exp=00000001", hi); end
        checks++; if (lo !== 32'h0000_0000) begin failures++; $display("FAIL b2b_second_lo got=%h exp=00000000", lo); end
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, chg, dz1);
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL b2b_third_hi got=%h exp=00000000", hi); end
        checks++; if (lo !== 32'h1) begin failures++; $display("FAIL b2b_third_lo got=%h exp=00000001", lo); end
        tick();
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_divzero();
        test_overflow();
        test_ignored();
        test_moves();
        test_start_priority();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
